ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//
// Streams host configuration words, LSB first, into a serial configuration
// flip-flop (ccff) chain of CHAIN_LEN flops. An optional second pass re-sends
// the same stream and compares the bits coming out of the chain tail against
// the bits being shifted in, flagging any difference as a sticky error.
//
// Ports
//   prog_clk      in   single clock, all state changes on its rising edge
//   prog_reset_n  in   synchronous active-low reset
//   start         in   begin a load sequence (honoured in IDLE and DONE)
//   verify_en     in   request a readback pass, captured together with start
//   abort         in   cancel the pass in progress (LOAD/VERIFY only)
//   cfg_data      in   configuration word, LSB shifted first
//   cfg_valid     in   cfg_data valid
//   cfg_ready     out  loader accepts cfg_data this cycle
//   ccff_head     out  serial bit into the chain
//   ccff_tail     in   serial bit out of the chain
//   prog_en       out  chain shift enable, one bit per enabled edge
//   busy          out  LOAD or VERIFY in progress
//   done          out  sequence completed
//   error         out  abort seen or readback mismatch (sticky until start)
//   bit_count     out  bits shifted in the current pass
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic                             prog_clk,
    input  logic                             prog_reset_n,
    input  logic                             start,
    input  logic                             verify_en,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                cfg_data,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    output logic                             ccff_head,
    input  logic                             ccff_tail,
    output logic                             prog_en,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(WORD_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [RW-1:0]      rem_q,   rem_d;
    logic [BW-1:0]      cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic               vfy_q,   vfy_d;

    logic [31:0]        left_bits;
    logic [RW-1:0]      word_len;

    // Bits still owed to the chain in this pass, capped at one word; the
    // upper bits of a final partial word are simply never shifted out.
    always_comb begin
        left_bits = 32'(CHAIN_LEN) - 32'(cnt_q);
        if (left_bits >= 32'(WORD_W)) begin
            word_len = RW'(WORD_W);
        end else begin
            word_len = RW'(left_bits);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vfy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vfy_q   <= vfy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        vfy_d     = vfy_q;
        cfg_ready = 1'b0;
        prog_en   = 1'b0;
        ccff_head = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    vfy_d   = verify_en;
                end
            end

            S_LOAD, S_VERIFY: begin
                if (abort) begin
                    // Abort wins over any handshake this cycle; the held word
                    // is dropped and the chain is left untouched.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    shift_d = '0;
                    rem_d   = '0;
                end else begin
                    if (rem_q != '0) begin
                        prog_en   = 1'b1;
                        ccff_head = shift_q[0];
                        shift_d   = shift_q >> 1;
                        rem_d     = rem_q - RW'(1);
                    end else begin
                        cfg_ready = 1'b1;
                        // The accepted word's first bit goes straight to the
                        // chain, so back-to-back words leave no idle cycle.
                        if (cfg_valid) begin
                            prog_en   = 1'b1;
                            ccff_head = cfg_data[0];
                            shift_d   = cfg_data >> 1;
                            rem_d     = word_len - RW'(1);
                        end
                    end

                    if (prog_en) begin
                        cnt_d = cnt_q + BW'(1);
                        if ((state_q == S_VERIFY) && (ccff_tail != ccff_head)) begin
                            err_d = 1'b1;
                        end
                        if (cnt_q == LAST_BIT) begin
                            shift_d = '0;
                            rem_d   = '0;
                            if ((state_q == S_LOAD) && vfy_q) begin
                                state_d = S_VERIFY;
                                cnt_d   = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The chain must not advance on the reset edge itself.
        if (!prog_reset_n) begin
            cfg_ready = 1'b0;
            prog_en   = 1'b0;
            ccff_head = 1'b0;
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done      = (state_q == S_DONE);
    assign error     = err_q;
    assign bit_count = cnt_q;

endmodule
